add_acc: RTL and testbench
==========================

ADD_ACC -- requirements
Module: add_acc

Interface
- REQ-001: Parameter WIDTH, default 8: operand and sum width in bits.
- REQ-002: Parameter SAT, default 1: 1 = saturate at 2^WIDTH-1; 0 = wrap modulo 2^WIDTH.
- REQ-003: Parameter MAX_TERMS, default 16: maximum operands per accumulation; CW = clog2(MAX_TERMS+1).
- REQ-004: The block SHALL have one clock and an asynchronous, active-low reset, with the ports named as in the table below.
- REQ-005: CLK  in  1  clock; all state changes on the rising edge.
- REQ-006: nRST  in  1  asynchronous reset, active low.
- REQ-007: add_begin  in  1  start pulse; sampled only in IDLE.
- REQ-008: add_valid  in  1  operand valid.
- REQ-009: ADD_IN  in  WIDTH  operand.
- REQ-010: add_last  in  1  marks the final operand; qualified by add_valid.
- REQ-011: add_ready  out  1  operand accepted this cycle when add_valid=1.
- REQ-012: add_ack  in  1  consumer has taken SUM.
- REQ-013: SUM  out  WIDTH  registered result.
- REQ-014: add_over  out  1  SUM valid; held until acknowledged.
- REQ-015: TERM_CNT  out  CW  number of operands accumulated.
- REQ-016: OVF  out  1  sticky overflow flag; present only when ADD_OVF_FLAG_EN is defined.

Function
- REQ-017: The FSM SHALL have three states: IDLE, ACC and HOLD.
- REQ-018: In IDLE with add_begin=1, the block SHALL clear the accumulator, TERM_CNT and OVF, and enter ACC on the next cycle.
- REQ-019: add_ready SHALL be 1 only in ACC; a beat SHALL transfer when add_valid=1 and add_ready=1.
- REQ-020: On each transfer, the accumulator SHALL compute acc + ADD_IN at WIDTH+1 bits, and TERM_CNT SHALL increment by 1.
- REQ-021: On a carry out of bit WIDTH-1, the result SHALL be all ones when SAT=1, and the low WIDTH bits when SAT=0.
- REQ-022: A transfer with add_last=1, or the transfer that makes TERM_CNT reach MAX_TERMS, SHALL move the FSM to HOLD.
- REQ-023: One cycle after that final transfer, SUM SHALL equal the final accumulator and add_over SHALL be 1.
- REQ-024: In HOLD, SUM, TERM_CNT, OVF and add_over SHALL remain stable until add_ack=1.
- REQ-025: In HOLD with add_ack=1, the FSM SHALL go to IDLE and add_over SHALL clear on the next cycle.
- REQ-026: add_begin in ACC or HOLD SHALL be ignored.
- REQ-027: add_ack outside HOLD SHALL be ignored.
- REQ-028: add_valid outside ACC SHALL be ignored, and no beat SHALL transfer.
- REQ-029: No timeout SHALL apply in ACC: add_valid=0 keeps the state indefinitely.

Reset
- REQ-030: While nRST=0, the FSM SHALL be in IDLE, and the accumulator, SUM, TERM_CNT, add_over, add_ready and OVF SHALL be 0.
- REQ-031: Reset asserted mid-accumulation or in HOLD SHALL discard the partial result, with no add_over pulse.

Configuration
- REQ-032: With ADD_OVF_FLAG_EN defined, OVF SHALL set on any transfer that carries out of bit WIDTH-1, in either SAT mode.
- REQ-033: With ADD_OVF_FLAG_EN defined, OVF SHALL stay set until the next accepted add_begin.
- REQ-034: Without ADD_OVF_FLAG_EN, the OVF port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
- REQ-035: The shared package add_pkg SHALL hold the state encodings (IDLE/ACC/HOLD) and the SAT mode constants.
- REQ-036: The one-step add SHALL be in the combinational sub-module sat_add (WIDTH, SAT), with outputs sum and carry.
- REQ-037: Every parameter combination SHALL be synthesizable.

Verification (WIDTH=8 unless stated)
- REQ-038: SAT=1: begin, then 100, 100, 60(last) -> next cycle SUM=255, TERM_CNT=3, add_over=1, OVF=1.
- REQ-039: SAT=0: begin, then 200, 100(last) -> SUM=44, OVF=1; then begin, then 10, 20(last) -> SUM=30, OVF=0.
- REQ-040: MAX_TERMS=4: five beats of 1, add_valid held, no last -> SUM=4, TERM_CNT=4, add_ready=0 after the 4th beat; 5th beat not taken.
- REQ-041: HOLD: add_ack held low for 10 cycles -> outputs stable; add_begin pulsed in HOLD is ignored; add_ack=1 -> IDLE, add_over=0 next cycle.
- REQ-042: nRST pulsed after 2 beats -> all outputs 0, no add_over; then begin, 3, 4(last) -> SUM=7, TERM_CNT=2.
- REQ-043: Single beat: begin, then 0(last) -> SUM=0, TERM_CNT=1, OVF=0; add_valid gaps between beats do not change the result.

Source files
------------

// File: rtl/add_pkg.sv
// -----------------------------------------------------------------------------
// add_pkg -- shared definitions for the add_acc accumulator slice.
//
// Contents:
//   add_state_e   : FSM state encoding (IDLE, ACC, HOLD)
//   SAT_WRAP      : sat_add mode constant, result wraps modulo 2^WIDTH
//   SAT_SATURATE  : sat_add mode constant, result clamps at 2^WIDTH-1
//   term_cnt_w()  : width of a counter able to hold 0..max_terms
// -----------------------------------------------------------------------------
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } add_state_e;

    localparam int SAT_WRAP     = 0;
    localparam int SAT_SATURATE = 1;

    // A count of 0..max_terms inclusive needs clog2(max_terms+1) bits.
    function automatic int term_cnt_w(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage : add_pkg

// File: rtl/sat_add.sv
// -----------------------------------------------------------------------------
// sat_add -- one combinational add step of the accumulator.
//
// The operands are added at WIDTH+1 bits. The extra bit is reported as carry.
// With SAT=SAT_SATURATE a carry clamps the result to all ones. With
// SAT=SAT_WRAP the low WIDTH bits are passed through unchanged.
//
// Parameters:
//   WIDTH  operand / result width in bits
//   SAT    SAT_SATURATE (1) or SAT_WRAP (0)
//
// Ports:
//   a      in   WIDTH  running accumulator value
//   b      in   WIDTH  new operand
//   sum    out  WIDTH  saturated or wrapped result
//   carry  out  1      carry out of bit WIDTH-1, independent of SAT
// -----------------------------------------------------------------------------
module sat_add
    import add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = SAT_SATURATE
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full_sum;

    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // so no branch can leave one holding its old value (no latch).
        full_sum = {1'b0, a} + {1'b0, b};
        carry    = full_sum[WIDTH];
        sum      = full_sum[WIDTH-1:0];
        if (carry && (SAT == SAT_SATURATE)) begin
            sum = '1;
        end
    end

endmodule : sat_add

// File: rtl/add_acc.sv
// -----------------------------------------------------------------------------
// add_acc -- streaming add accumulator with a result hold/acknowledge handshake.
//
// Operation:
//   IDLE : add_begin clears the accumulator, TERM_CNT and OVF, then moves to ACC.
//   ACC  : add_ready=1. Each add_valid beat is added through sat_add and
//          TERM_CNT increments. A beat with add_last, or the beat that brings
//          TERM_CNT to MAX_TERMS, latches SUM, raises add_over and moves to HOLD.
//          ACC has no timeout.
//   HOLD : SUM, TERM_CNT, OVF and add_over stay frozen until add_ack. On
//          add_ack the FSM returns to IDLE.
//   add_begin outside IDLE, add_ack outside HOLD and add_valid outside ACC are
//   ignored.
//
// Parameters:
//   WIDTH      operand and sum width
//   SAT        1 = saturate at 2^WIDTH-1, 0 = wrap modulo 2^WIDTH
//   MAX_TERMS  maximum operands per accumulation (TERM_CNT width derives from it)
//
// Ports:
//   CLK        in   1      clock, rising edge
//   nRST       in   1      asynchronous reset, active low
//   add_begin  in   1      start pulse, sampled in IDLE only
//   add_valid  in   1      operand valid
//   ADD_IN     in   WIDTH  operand
//   add_last   in   1      final operand, qualified by add_valid
//   add_ready  out  1      operand accepted this cycle when add_valid=1
//   add_ack    in   1      consumer has taken SUM
//   SUM        out  WIDTH  registered result
//   add_over   out  1      SUM valid, held until acknowledged
//   TERM_CNT   out  CW     operands accumulated, CW = clog2(MAX_TERMS+1)
//   OVF        out  1      sticky carry flag, present only when the macro
//                          ADD_OVF_FLAG_EN is defined
//
// Build option:
//   ADD_OVF_FLAG_EN  adds the OVF port. OVF sets on any beat that carries out
//                    of bit WIDTH-1, in either SAT mode, and clears on the next
//                    accepted add_begin. When the macro is undefined, the port
//                    and its register are absent.
// -----------------------------------------------------------------------------
module add_acc
    import add_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int SAT       = SAT_SATURATE,
    parameter  int MAX_TERMS = 16,
    localparam int CW        = term_cnt_w(MAX_TERMS)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             add_begin,
    input  logic             add_valid,
    input  logic [WIDTH-1:0] ADD_IN,
    input  logic             add_last,
    output logic             add_ready,
    input  logic             add_ack,
    output logic [WIDTH-1:0] SUM,
    output logic             add_over,
`ifdef ADD_OVF_FLAG_EN
    output logic             OVF,
`endif
    output logic [CW-1:0]    TERM_CNT
);

    add_state_e       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] step_sum;
    logic             step_carry;
    logic [CW-1:0]    cnt_next;
    logic             beat;
    logic             final_beat;

    sat_add #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_sat_add (
        .a     (acc),
        .b     (ADD_IN),
        .sum   (step_sum),
        .carry (step_carry)
    );

    // add_ready is a register that is 1 exactly while the FSM is in ACC, so a
    // handshake on it is the same as being in ACC with add_valid high.
    assign beat       = add_valid && add_ready;
    assign cnt_next   = TERM_CNT + CW'(1);
    assign final_beat = beat && (add_last || (cnt_next == CW'(MAX_TERMS)));

    // NOTE: state registers use non-blocking assignments, so every branch
    // below reads the values from before this clock edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            acc       <= '0;
            SUM       <= '0;
            TERM_CNT  <= '0;
            add_over  <= 1'b0;
            add_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (add_begin) begin
                        acc       <= '0;
                        TERM_CNT  <= '0;
                        add_ready <= 1'b1;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc      <= step_sum;
                        TERM_CNT <= cnt_next;
                        if (final_beat) begin
                            SUM       <= step_sum;
                            add_over  <= 1'b1;
                            add_ready <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (add_ack) begin
                        add_over <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    add_over  <= 1'b0;
                    add_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ADD_OVF_FLAG_EN
    // The flag records a carry even in SAT mode, where SUM alone would only
    // show a clamped value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            OVF <= 1'b0;
        end else if ((state == IDLE) && add_begin) begin
            OVF <= 1'b0;
        end else if (beat && step_carry) begin
            OVF <= 1'b1;
        end
    end
`endif

endmodule : add_acc

// File: tb/tb_add_acc.sv
// -----------------------------------------------------------------------------
// tb_add_acc -- self-checking bench for add_acc.
//
// Three instances share one stimulus bus. sel routes add_begin, add_valid and
// add_ack to one instance at a time and chooses which outputs are observed:
//   0 : WIDTH=8, SAT=1, MAX_TERMS=16
//   1 : WIDTH=8, SAT=0, MAX_TERMS=16
//   2 : WIDTH=8, SAT=1, MAX_TERMS=4
// Expected results are pushed to a scoreboard queue as operands are driven.
// They are popped and compared when add_over is seen.
// -----------------------------------------------------------------------------
module tb_add_acc;

    typedef struct {
        logic [7:0] sum;
        logic [4:0] cnt;
        logic       ovf;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [1:0] sel;
    logic       add_begin, add_valid, add_last, add_ack;
    logic [7:0] ADD_IN;

    logic       ready_w [3];
    logic       over_w  [3];
    logic       ovf_w   [3];
    logic [7:0] sum_w   [3];
    logic [4:0] cnt0, cnt1;
    logic [2:0] cnt2;

    logic       obs_ready, obs_over, obs_ovf;
    logic [7:0] obs_sum;
    logic [4:0] obs_cnt;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    add_acc #(.WIDTH(8), .SAT(1), .MAX_TERMS(16)) u_sat (
        .CLK(CLK), .nRST(nRST),
        .add_begin(add_begin && sel == 2'd0), .add_valid(add_valid && sel == 2'd0),
        .ADD_IN(ADD_IN), .add_last(add_last), .add_ready(ready_w[0]),
        .add_ack(add_ack && sel == 2'd0), .SUM(sum_w[0]), .add_over(over_w[0]),
`ifdef ADD_OVF_FLAG_EN
        .OVF(ovf_w[0]),
`endif
        .TERM_CNT(cnt0)
    );

    add_acc #(.WIDTH(8), .SAT(0), .MAX_TERMS(16)) u_wrap (
        .CLK(CLK), .nRST(nRST),
        .add_begin(add_begin && sel == 2'd1), .add_valid(add_valid && sel == 2'd1),
        .ADD_IN(ADD_IN), .add_last(add_last), .add_ready(ready_w[1]),
        .add_ack(add_ack && sel == 2'd1), .SUM(sum_w[1]), .add_over(over_w[1]),
`ifdef ADD_OVF_FLAG_EN
        .OVF(ovf_w[1]),
`endif
        .TERM_CNT(cnt1)
    );

    add_acc #(.WIDTH(8), .SAT(1), .MAX_TERMS(4)) u_max4 (
        .CLK(CLK), .nRST(nRST),
        .add_begin(add_begin && sel == 2'd2), .add_valid(add_valid && sel == 2'd2),
        .ADD_IN(ADD_IN), .add_last(add_last), .add_ready(ready_w[2]),
        .add_ack(add_ack && sel == 2'd2), .SUM(sum_w[2]), .add_over(over_w[2]),
`ifdef ADD_OVF_FLAG_EN
        .OVF(ovf_w[2]),
`endif
        .TERM_CNT(cnt2)
    );

`ifndef ADD_OVF_FLAG_EN
    assign ovf_w[0] = 1'b0;
    assign ovf_w[1] = 1'b0;
    assign ovf_w[2] = 1'b0;
`endif

    always_comb begin
        obs_ready = ready_w[0];
        obs_over  = over_w[0];
        obs_ovf   = ovf_w[0];
        obs_sum   = sum_w[0];
        obs_cnt   = cnt0;
        case (sel)
            2'd1: begin
                obs_ready = ready_w[1]; obs_over = over_w[1]; obs_ovf = ovf_w[1];
                obs_sum = sum_w[1]; obs_cnt = cnt1;
            end
            2'd2: begin
                obs_ready = ready_w[2]; obs_over = over_w[2]; obs_ovf = ovf_w[2];
                obs_sum = sum_w[2]; obs_cnt = {2'b00, cnt2};
            end
            default: ;
        endcase
    end

    // Reference for one add step: bit 8 is the carry, bits 7:0 the result.
    function automatic logic [8:0] model_step(input logic [7:0] a, input logic [7:0] b,
                                              input bit sat);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t[8] && sat) t[7:0] = 8'hFF;
        return t;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_begin();
        add_begin = 1'b1;
        tick();
        add_begin = 1'b0;
        checks++;
        if (obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL begin_ready sel=%0d got=%b exp=1", sel, obs_ready);
        end
    endtask

    task automatic send_beat(input logic [7:0] data, input logic last);
        int waited = 0;
        add_valid = 1'b1;
        ADD_IN    = data;
        add_last  = last;
        while (obs_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (obs_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout sel=%0d data=%0d ready=%b", sel, data, obs_ready);
        end else begin
            tick();
        end
        add_valid = 1'b0;
        add_last  = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int   waited = 0;
        exp_t e;
        while (obs_over !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (obs_over !== 1'b1) begin
            failures++;
            $display("FAIL %s_over_timeout got=%b exp=1", name, obs_over);
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard_empty got=result exp=none", name);
        end else begin
            e = sb.pop_front();
            if (obs_sum !== e.sum) begin
                failures++;
                $display("FAIL %s_sum got=%0d exp=%0d", name, obs_sum, e.sum);
            end
            checks++;
            if (obs_cnt !== e.cnt) begin
                failures++;
                $display("FAIL %s_term_cnt got=%0d exp=%0d", name, obs_cnt, e.cnt);
            end
`ifdef ADD_OVF_FLAG_EN
            checks++;
            if (obs_ovf !== e.ovf) begin
                failures++;
                $display("FAIL %s_ovf got=%b exp=%b", name, obs_ovf, e.ovf);
            end
`endif
        end
    endtask

    task automatic ack_result(input string name);
        add_ack = 1'b1;
        tick();
        add_ack = 1'b0;
        checks++;
        if (obs_over !== 1'b0 || obs_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_ack got over=%b ready=%b exp over=0 ready=0",
                     name, obs_over, obs_ready);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if (obs_ready !== 1'b0 || obs_over !== 1'b0 || obs_sum !== 8'd0 ||
                obs_cnt !== 5'd0 || obs_ovf !== 1'b0) begin
                failures++;
                $display("FAIL reset_state sel=%0d got ready=%b over=%b sum=%0d cnt=%0d ovf=%b exp all 0",
                         s, obs_ready, obs_over, obs_sum, obs_cnt, obs_ovf);
            end
        end
        @(negedge CLK);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_sat();
        sel = 2'd0;
        do_begin();
        sb.push_back('{sum: 8'd255, cnt: 5'd3, ovf: 1'b1});
        send_beat(8'd100, 1'b0);
        send_beat(8'd100, 1'b0);
        send_beat(8'd60, 1'b1);
        checks++;
        if (obs_over !== 1'b1) begin
            failures++;
            $display("FAIL sat_latency got over=%b exp=1", obs_over);
        end
        wait_result("sat");
        ack_result("sat");
    endtask

    task automatic test_wrap();
        sel = 2'd1;
        do_begin();
        sb.push_back('{sum: 8'd44, cnt: 5'd2, ovf: 1'b1});
        send_beat(8'd200, 1'b0);
        send_beat(8'd100, 1'b1);
        wait_result("wrap1");
        ack_result("wrap1");
        do_begin();
        sb.push_back('{sum: 8'd30, cnt: 5'd2, ovf: 1'b0});
        send_beat(8'd10, 1'b0);
        send_beat(8'd20, 1'b1);
        wait_result("wrap2");
        ack_result("wrap2");
    endtask

    task automatic test_max_terms();
        int taken = 0;
        sel = 2'd2;
        do_begin();
        sb.push_back('{sum: 8'd4, cnt: 5'd4, ovf: 1'b0});
        add_valid = 1'b1;
        ADD_IN    = 8'd1;
        add_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (obs_ready === 1'b1) taken++;
            tick();
        end
        checks++;
        if (taken != 4 || obs_ready !== 1'b0) begin
            failures++;
            $display("FAIL max_terms_taken got taken=%0d ready=%b exp taken=4 ready=0",
                     taken, obs_ready);
        end
        add_valid = 1'b0;
        wait_result("max_terms");
        ack_result("max_terms");
    endtask

    task automatic test_hold();
        sel = 2'd0;
        do_begin();
        sb.push_back('{sum: 8'd11, cnt: 5'd2, ovf: 1'b0});
        send_beat(8'd5, 1'b0);
        send_beat(8'd6, 1'b1);
        wait_result("hold");
        for (int i = 0; i < 10; i++) begin
            add_begin = (i == 3);
            add_valid = (i == 5);
            ADD_IN    = 8'd200;
            tick();
            add_begin = 1'b0;
            add_valid = 1'b0;
            checks++;
            if (obs_over !== 1'b1 || obs_sum !== 8'd11 || obs_cnt !== 5'd2 ||
                obs_ready !== 1'b0 || obs_ovf !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d got over=%b sum=%0d cnt=%0d ready=%b ovf=%b exp 1/11/2/0/0",
                         i, obs_over, obs_sum, obs_cnt, obs_ready, obs_ovf);
            end
        end
        ack_result("hold");
        // A stray ack in IDLE must not disturb the next accumulation.
        add_ack = 1'b1;
        tick();
        add_ack = 1'b0;
        do_begin();
        sb.push_back('{sum: 8'd9, cnt: 5'd1, ovf: 1'b0});
        send_beat(8'd9, 1'b1);
        wait_result("idle_ack");
        ack_result("idle_ack");
    endtask

    task automatic test_reset_mid();
        sel = 2'd0;
        do_begin();
        send_beat(8'd1, 1'b0);
        send_beat(8'd2, 1'b0);
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (obs_ready !== 1'b0 || obs_over !== 1'b0 || obs_sum !== 8'd0 || obs_cnt !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid got ready=%b over=%b sum=%0d cnt=%0d exp all 0",
                     obs_ready, obs_over, obs_sum, obs_cnt);
        end
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_over !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_no_over cycle=%0d got=%b exp=0", i, obs_over);
            end
        end
        do_begin();
        sb.push_back('{sum: 8'd7, cnt: 5'd2, ovf: 1'b0});
        send_beat(8'd3, 1'b0);
        send_beat(8'd4, 1'b1);
        wait_result("after_reset");
        // Reset while holding a result drops it without a new add_over.
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (obs_over !== 1'b0 || obs_sum !== 8'd0 || obs_cnt !== 5'd0) begin
            failures++;
            $display("FAIL reset_hold got over=%b sum=%0d cnt=%0d exp all 0",
                     obs_over, obs_sum, obs_cnt);
        end
        @(negedge CLK);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_single_gaps();
        logic [7:0] vals [6];
        logic [8:0] t;
        logic [7:0] acc;
        logic       ovf;
        sel = 2'd0;
        do_begin();
        sb.push_back('{sum: 8'd0, cnt: 5'd1, ovf: 1'b0});
        send_beat(8'd0, 1'b1);
        wait_result("single");
        ack_result("single");
        for (int s = 0; s < 2; s++) begin
            sel = 2'(s);
            acc = 8'd0;
            ovf = 1'b0;
            for (int i = 0; i < 6; i++) begin
                vals[i] = 8'($urandom_range(0, 120));
                t       = model_step(acc, vals[i], s == 0);
                acc     = t[7:0];
                ovf     = ovf | t[8];
            end
            do_begin();
            sb.push_back('{sum: acc, cnt: 5'd6, ovf: ovf});
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                send_beat(vals[i], i == 5);
            end
            wait_result(s == 0 ? "gaps_sat" : "gaps_wrap");
            ack_result(s == 0 ? "gaps_sat" : "gaps_wrap");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel       = 2'd0;
        add_begin = 1'b0;
        add_valid = 1'b0;
        add_last  = 1'b0;
        add_ack   = 1'b0;
        ADD_IN    = 8'd0;
        test_reset();
        test_sat();
        test_wrap();
        test_max_terms();
        test_hold();
        test_reset_mid();
        test_single_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_add_acc
